// File: rtl/snake_pkg.sv
// Shared types for the snake game blocks: grid geometry, cell coordinates,
// body occupancy bitmap and the apple placer state encoding.
package snake_pkg;

    localparam int GRID_BITS = 3;
    localparam int CELLS     = 1 << (2 * GRID_BITS);

    typedef struct packed {
        logic [GRID_BITS-1:0] x;
        logic [GRID_BITS-1:0] y;
    } coord_t;

    typedef logic [CELLS-1:0] occ_map_t;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CHECK,
        SCAN
    } placer_state_e;

    // Linear successor of a cell in {x,y} order, wrapping the last cell to {0,0}.
    function automatic coord_t coord_next(coord_t c);
        return coord_t'({c.x, c.y} + (2 * GRID_BITS)'(1));
    endfunction

endpackage

// File: rtl/apple_placer.sv
// Places a new apple on a free grid cell using the LFSR coordinate stream.
// Optional APPLE_SCAN_FALLBACK_EN adds a linear scan after MAX_TRIES misses.
module apple_placer
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   place_req,
    input  logic [2*GRID_BITS-1:0] rnd_coord,
    input  logic [CELLS-1:0]       occupied,
    output logic [GRID_BITS-1:0]   apple_x,
    output logic [GRID_BITS-1:0]   apple_y,
    output logic                   apple_valid,
    output logic                   busy,
    output logic                   place_done,
    output logic                   board_full
);

    localparam int              TW      = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]   TRY_MAX = TW'(MAX_TRIES);

    placer_state_e   state;
    coord_t          cand;
    logic [TW-1:0]   try_cnt;

`ifdef APPLE_SCAN_FALLBACK_EN
    logic [2*GRID_BITS-1:0] scan_cnt;
    coord_t                 nxt;
    assign nxt = coord_next(cand);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
            busy        <= 1'b0;
            place_done  <= 1'b0;
            board_full  <= 1'b0;
            cand        <= '0;
            try_cnt     <= '0;
`ifdef APPLE_SCAN_FALLBACK_EN
            scan_cnt    <= '0;
`endif
        end else begin
            place_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (place_req) begin
                        apple_valid <= 1'b0;
                        board_full  <= 1'b0;
                        if (&occupied) begin
                            board_full <= 1'b1;
                            place_done <= 1'b1;
                        end else begin
                            state   <= SAMPLE;
                            busy    <= 1'b1;
                            try_cnt <= '0;
                        end
                    end
                end
                SAMPLE: begin
                    cand  <= coord_t'(rnd_coord);
                    state <= CHECK;
                    if (try_cnt != TRY_MAX)
                        try_cnt <= try_cnt + TW'(1);
                end
                CHECK: begin
                    if (!occupied[{cand.x, cand.y}]) begin
                        apple_x     <= cand.x;
                        apple_y     <= cand.y;
                        apple_valid <= 1'b1;
                        place_done  <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
`ifdef APPLE_SCAN_FALLBACK_EN
                    end else if (try_cnt == TRY_MAX) begin
                        scan_cnt <= '0;
                        state    <= SCAN;
`endif
                    end else begin
                        state <= SAMPLE;
                    end
                end
`ifdef APPLE_SCAN_FALLBACK_EN
                // The cell in cand already failed, so 63 steps cover every other cell.
                SCAN: begin
                    cand <= nxt;
                    if (!occupied[{nxt.x, nxt.y}]) begin
                        apple_x     <= nxt.x;
                        apple_y     <= nxt.y;
                        apple_valid <= 1'b1;
                        place_done  <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (scan_cnt == (2 * GRID_BITS)'(CELLS - 2)) begin
                        board_full <= 1'b1;
                        place_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        scan_cnt <= scan_cnt + (2 * GRID_BITS)'(1);
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placer.sv
// Self-checking bench for apple_placer: table of placement requests scored at
// place_done, plus hand sequences for busy requests, sticky full and reset abort.
module tb_apple_placer;

    logic        clk = 1'b0;
    logic        reset;
    logic        place_req;
    logic [5:0]  rnd_coord;
    logic [63:0] occupied;
    logic [2:0]  apple_x;
    logic [2:0]  apple_y;
    logic        apple_valid;
    logic        busy;
    logic        place_done;
    logic        board_full;

    int passed = 0;
    int total  = 0;

    apple_placer #(.MAX_TRIES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .place_req  (place_req),
        .rnd_coord  (rnd_coord),
        .occupied   (occupied),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .apple_valid(apple_valid),
        .busy       (busy),
        .place_done (place_done),
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] occ;
        logic [5:0]  rnd0;
        logic [5:0]  rnd1;
        int          exp_x;
        int          exp_y;
        int          exp_valid;
        int          exp_full;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // rnd0 is presented for the first SAMPLE, rnd1 from the second one onward.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int   lat;
        occupied  = v.occ;
        rnd_coord = v.rnd0;
        place_req = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        place_req = 1'b0;
        lat = 1;
        check("busy_after_accept", busy, v.exp_busy);
        check("valid_cleared_at_accept", apple_valid, 0);
        while (!place_done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) rnd_coord = v.rnd1;
        end
        e = sb_q.pop_front();
        if (!place_done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", lat, e.exp_lat);
            check("apple_x", apple_x, e.exp_x);
            check("apple_y", apple_y, e.exp_y);
            check("apple_valid", apple_valid, e.exp_valid);
            check("board_full", board_full, e.exp_full);
            @(posedge clk); #1;
            check("done_single_cycle", place_done, 0);
            check("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        int dones;
        vec_t fb;

        vecs[0] = '{64'd0, 6'b101_011, 6'b101_011, 5, 3, 1, 0, 3, 1};
        vecs[1] = '{64'd1 << 43, 6'd43, 6'd10, 1, 2, 1, 0, 5, 1};
        vecs[2] = '{64'd0, 6'd0, 6'd0, 0, 0, 1, 0, 3, 1};
        vecs[3] = '{~(64'd1 << 63), 6'd63, 6'd63, 7, 7, 1, 0, 3, 1};
        vecs[4] = '{~64'd0, 6'd5, 6'd5, 7, 7, 0, 1, 1, 0};
        vecs[5] = '{(64'd1 << 43) | (64'd1 << 10), 6'd10, 6'd20, 2, 4, 1, 0, 5, 1};

        reset = 1'b1; place_req = 1'b0; rnd_coord = '0; occupied = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_apple_x", apple_x, 0);
        check("rst_apple_y", apple_y, 0);
        check("rst_apple_valid", apple_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_place_done", place_done, 0);
        check("rst_board_full", board_full, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            if (i == 4) begin
                repeat (3) @(posedge clk);
                #1;
                check("board_full_sticky", board_full, 1);
            end
        end

`ifdef APPLE_SCAN_FALLBACK_EN
        // 8 failed tries (16 cycles) then SCAN 61,62,63,0 commits at the 4th scan step.
        fb = '{~64'd1, 6'd60, 6'd60, 0, 0, 1, 0, 21, 1};
        run_vec(fb);
`endif

        // Request pulsed while busy must be ignored.
        occupied = '0; rnd_coord = 6'd9; place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        @(posedge clk); #1;
        place_req = 1'b1;
        dones = place_done ? 1 : 0;
        @(posedge clk); #1;
        place_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (place_done) dones++;
            @(posedge clk); #1;
        end
        check("busy_req_single_done", dones, 1);
        check("busy_req_apple_x", apple_x, 1);
        check("busy_req_apple_y", apple_y, 1);
        check("busy_req_idle", busy, 0);

        // Reset while in CHECK aborts without a completion pulse.
        occupied = '0; rnd_coord = 6'd62; place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_apple_x", apple_x, 0);
        check("abort_apple_y", apple_y, 0);
        check("abort_valid", apple_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", place_done, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (place_done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_stays_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
